// File: rtl/crop_pkg.sv
// crop_pkg: types and helpers shared by the crop window controller.
//   crop_state_e  : controller FSM state encoding
//   SOF_BIT       : m_axis_tuser bit marking the first pixel of the window
//   EOL_BIT       : m_axis_tuser bit marking the last pixel of a window line
//   clamp_origin  : limits a requested origin so the window stays in-frame
package crop_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } crop_state_e;

   localparam int SOF_BIT = 0;
   localparam int EOL_BIT = 1;

   // Returns min(req, lim). Callers widen to 16 bits and truncate the result.
   function automatic logic [15:0] clamp_origin(input logic [15:0] req,
                                                input logic [15:0] lim);
      return (req > lim) ? lim : req;
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: 1-deep AXI-Stream register slice.
//   clk, s_axis_resetn : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data : upstream side
//   m_valid/m_ready/m_data : downstream side (registered)
// Handshake: a beat moves when valid && ready on the same rising edge;
// a source holds valid and data stable until that happens, and ready may
// depend combinationally on the sink's own state only.
module axis_reg_slice #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  s_axis_resetn,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
);

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;

   // Can accept when empty or when the held beat leaves this cycle.
   assign s_ready = !valid_q || m_ready;
   assign m_valid = valid_q;
   assign m_data  = data_q;

   always_ff @(posedge clk or negedge s_axis_resetn) begin
      if (!s_axis_resetn) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (s_valid && s_ready) begin
         valid_q <= 1'b1;
         data_q  <= s_data;
      end else if (m_ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/crop_window_ctrl.sv
// crop_window_ctrl: forwards an OUT_ROWS x OUT_COLS window of each input
// frame, tagging first pixel, end-of-line and end-of-frame.
//   clk, s_axis_resetn      : clock, asynchronous active-low reset
//   s_axis_*                : single-pixel input stream, tuser_sof on pixel (0,0)
//   crop_x0, crop_y0        : requested window origin, sampled at each SOF
//   m_axis_*                : cropped output stream (tuser[0]=first, [1]=EOL)
//   crop_clamped            : origin was reduced for the current frame
//   frame_err               : one-cycle pulse when a frame is aborted by SOF
//   busy                    : controller is not idle
module crop_window_ctrl
   import crop_pkg::*;
#(
   parameter int PIXEL_BIT_WIDTH = 16,
   parameter int IN_ROWS         = 100,
   parameter int IN_COLS         = 160,
   parameter int OUT_ROWS        = 48,
   parameter int OUT_COLS        = 48
) (
   input  logic                       clk,
   input  logic                       s_axis_resetn,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
   input  logic                       s_axis_tuser_sof,
   input  logic [$clog2(IN_COLS)-1:0] crop_x0,
   input  logic [$clog2(IN_ROWS)-1:0] crop_y0,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
   output logic [1:0]                 m_axis_tuser,
   output logic                       m_axis_tlast,
   output logic                       crop_clamped,
   output logic                       frame_err,
   output logic                       busy
);

   localparam int COL_W   = $clog2(IN_COLS);
   localparam int ROW_W   = $clog2(IN_ROWS);
   localparam int COLX_W  = COL_W + 1;
   localparam int ROWX_W  = ROW_W + 1;
   localparam int SLICE_W = PIXEL_BIT_WIDTH + 3;

   crop_state_e      state_q, state_d;
   logic [COL_W-1:0] col_q, col_d, ocol_q, ocol_d, x0_q, x0_d;
   logic [ROW_W-1:0] row_q, row_d, orow_q, orow_d, y0_q, y0_d;
   logic             clamped_q, clamped_d;
   logic             frame_err_q, frame_err_d;
   logic             busy_q, busy_d;

   logic [COL_W-1:0] x0_new, x0_cur, col_cur, ocol_cur;
   logic [ROW_W-1:0] y0_new, y0_cur, row_cur, orow_cur;
   logic             clamp_new, live, in_window, accept, push;
   logic             col_last, row_last, ocol_last, orow_last, win_last, first_pix;
   logic [1:0]       user_in;
   logic             slice_s_ready;
   logic [SLICE_W-1:0] slice_m_data;

   // Origin candidates for a beat that carries SOF.
   assign x0_new    = COL_W'(clamp_origin(16'(crop_x0), 16'(IN_COLS - OUT_COLS)));
   assign y0_new    = ROW_W'(clamp_origin(16'(crop_y0), 16'(IN_ROWS - OUT_ROWS)));
   assign clamp_new = (x0_new != crop_x0) || (y0_new != crop_y0);

   // A SOF beat is position (0,0) of a fresh frame and is judged against the
   // origin being latched on this very beat, not the stale shadow copy.
   assign x0_cur   = s_axis_tuser_sof ? x0_new : x0_q;
   assign y0_cur   = s_axis_tuser_sof ? y0_new : y0_q;
   assign col_cur  = s_axis_tuser_sof ? '0 : col_q;
   assign row_cur  = s_axis_tuser_sof ? '0 : row_q;
   assign ocol_cur = s_axis_tuser_sof ? '0 : ocol_q;
   assign orow_cur = s_axis_tuser_sof ? '0 : orow_q;

   assign live      = s_axis_tuser_sof || (state_q == ST_ACTIVE);
   assign in_window = live
                   && (col_cur >= x0_cur)
                   && ({1'b0, col_cur} < ({1'b0, x0_cur} + COLX_W'(OUT_COLS)))
                   && (row_cur >= y0_cur)
                   && ({1'b0, row_cur} < ({1'b0, y0_cur} + ROWX_W'(OUT_ROWS)));

   // Only beats bound for the output register can be back-pressured.
   assign s_axis_tready = !in_window || slice_s_ready;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign push          = accept && in_window;

   assign col_last  = (col_cur == COL_W'(IN_COLS - 1));
   assign row_last  = (row_cur == ROW_W'(IN_ROWS - 1));
   assign ocol_last = (ocol_cur == COL_W'(OUT_COLS - 1));
   assign orow_last = (orow_cur == ROW_W'(OUT_ROWS - 1));
   assign win_last  = ocol_last && orow_last;
   assign first_pix = (ocol_cur == '0) && (orow_cur == '0);

   always_comb begin
      user_in          = '0;
      user_in[SOF_BIT] = first_pix;
      user_in[EOL_BIT] = ocol_last;
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      ocol_d      = ocol_q;
      orow_d      = orow_q;
      x0_d        = x0_q;
      y0_d        = y0_q;
      clamped_d   = clamped_q;
      frame_err_d = accept && s_axis_tuser_sof && (state_q == ST_ACTIVE);
      if (accept) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_cur + 1'b1;
         end else begin
            col_d = col_cur + 1'b1;
            row_d = row_cur;
         end
         if (s_axis_tuser_sof) begin
            x0_d      = x0_new;
            y0_d      = y0_new;
            clamped_d = clamp_new;
            ocol_d    = '0;
            orow_d    = '0;
            state_d   = ST_ACTIVE;
         end
         if (push) begin
            if (ocol_last) begin
               ocol_d = '0;
               orow_d = orow_cur + 1'b1;
            end else begin
               ocol_d = ocol_cur + 1'b1;
               orow_d = orow_cur;
            end
         end
         // A window ending on the frame's final beat has nothing left to drain.
         if (push && win_last) begin
            state_d = (col_last && row_last) ? ST_IDLE : ST_DRAIN;
         end else if (!s_axis_tuser_sof && (state_q == ST_DRAIN) && col_last && row_last) begin
            state_d = ST_IDLE;
         end
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge s_axis_resetn) begin
      if (!s_axis_resetn) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         ocol_q      <= '0;
         orow_q      <= '0;
         x0_q        <= '0;
         y0_q        <= '0;
         clamped_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         ocol_q      <= ocol_d;
         orow_q      <= orow_d;
         x0_q        <= x0_d;
         y0_q        <= y0_d;
         clamped_q   <= clamped_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   axis_reg_slice #(
      .DATA_WIDTH (SLICE_W)
   ) u_out_slice (
      .clk           (clk),
      .s_axis_resetn (s_axis_resetn),
      .s_valid       (push),
      .s_ready       (slice_s_ready),
      .s_data        ({win_last, user_in, s_axis_tdata}),
      .m_valid       (m_axis_tvalid),
      .m_ready       (m_axis_tready),
      .m_data        (slice_m_data)
   );

   assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = slice_m_data;
   assign crop_clamped = clamped_q;
   assign frame_err    = frame_err_q;
   assign busy         = busy_q;

endmodule

// File: doc/crop_window_ctrl.md
# crop_window_ctrl

Frame-level crop controller downstream of the burst-to-pixel sequentializer. It receives the single-pixel AXI-Stream, tracks each pixel's row and column, and latches the crop origin once per frame. It forwards only the OUT_ROWS×OUT_COLS window, adding start-of-frame, end-of-line and end-of-frame markers, and discards all other pixels without stalling upstream.

## Interface
- PIXEL_BIT_WIDTH, 16, bits per pixel
- IN_ROWS, 100, input frame rows
- IN_COLS, 160, input frame columns
- OUT_ROWS, 48, crop window rows (≤ IN_ROWS)
- OUT_COLS, 48, crop window columns (≤ IN_COLS)

- clk  in  1  single clock
- s_axis_resetn  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tready  out  1  input pixel ready
- s_axis_tdata  in  PIXEL_BIT_WIDTH  input pixel
- s_axis_tuser_sof  in  1  beat is pixel (0,0) of a frame
- crop_x0  in  $clog2(IN_COLS)  requested window left column
- crop_y0  in  $clog2(IN_ROWS)  requested window top row
- m_axis_tvalid  out  1  output pixel valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  PIXEL_BIT_WIDTH  output pixel
- m_axis_tuser  out  2  [0] first window pixel, [1] last pixel of a window line
- m_axis_tlast  out  1  last window pixel of the frame
- crop_clamped  out  1  origin clamped for the current frame
- frame_err  out  1  one-cycle pulse on an aborted frame
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACTIVE, DRAIN.
  - IDLE: s_axis_tready=1. Non-SOF beats are discarded.
  - Accepted SOF, in any state: go to ACTIVE.
  - ACTIVE: beats are counted. After the last window pixel is accepted, go to DRAIN.
  - DRAIN: s_axis_tready=1 and beats are discarded. On beat IN_ROWS·IN_COLS−1, go to IDLE; an accepted SOF goes to ACTIVE.
- At an accepted SOF:
  - x0_eff = min(crop_x0, IN_COLS−OUT_COLS); y0_eff = min(crop_y0, IN_ROWS−OUT_ROWS).
  - Both are latched into shadow registers. crop_clamped is set if either was reduced; it holds until the next SOF.
  - Mid-frame changes to crop_x0/crop_y0 have no effect.
- Position counters:
  - col counts 0..IN_COLS−1 and wraps; row increments on wrap.
  - The SOF beat is position (0,0), i.e. col←1 and row←0 after it.
  - Counters advance only on s_axis_tvalid && s_axis_tready.
- In-window condition: x0_eff ≤ col < x0_eff+OUT_COLS and y0_eff ≤ row < y0_eff+OUT_ROWS. All compares are unsigned, with sums widened by 1 bit.
- Output counters ocol (0..OUT_COLS−1) and orow track the window position.
  - tuser[0] = (orow=0 && ocol=0).
  - tuser[1] = (ocol=OUT_COLS−1).
  - tlast = (ocol=OUT_COLS−1 && orow=OUT_ROWS−1).
- Early SOF, received while ACTIVE before tlast was emitted:
  - frame_err pulses on the cycle after the SOF is accepted.
  - The window state is restarted from the SOF.
  - A pixel already held in the output register is still delivered.
  - tlast is never emitted for the aborted frame.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE and all counters 0. Outputs reset to m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, crop_clamped=0, frame_err=0, busy=0.
- Output uses a 1-deep register slice. Latency is 1 cycle from an accepted in-window beat to m_axis_tvalid.
- s_axis_tready = !in_window || !m_axis_tvalid || m_axis_tready, and is 1 in IDLE and DRAIN.
  - Out-of-window beats never stall.
  - Full throughput of one pixel per cycle with m_axis_tready=1.
- m_axis_tvalid and all m_axis payload bits stay stable until m_axis_tready, per AXI-Stream.
- busy is registered and follows the state.
- A SOF accepted on the same cycle as the frame's last beat is treated as the new frame's SOF; DRAIN→ACTIVE is taken directly.

## Structure
- Package crop_pkg holds:
  - the state enum typedef
  - the user-bit index localparams SOF_BIT=0 and EOL_BIT=1
  - a function computing the clamped origin
- Sub-module axis_reg_slice (parameter DATA_WIDTH) is the 1-deep output register carrying {tlast, tuser, tdata}. Its ports are clk, s_axis_resetn and valid/ready.

## Test plan
- Crop (0,0), 160×100 frame, m_axis_tready=1:
  - 2304 outputs = pixels row·160+col for row, col < 48
  - tuser[1] every 48th beat; tlast only on beat 2304
  - crop_clamped=0
- Crop (112,52):
  - first output = input index 52·160+112 = 8432; last = 15999 with tlast
  - no clamp
- Crop (150,90) → window clamped to (112,52), output identical to the previous case, crop_clamped=1. crop_x0 changed mid-frame → no effect.
- Random m_axis_tready at 30% duty:
  - output sequence identical to the stall-free case
  - m_axis payload stable while stalled
  - out-of-window beats never see tready=0
- Early SOF after 1000 input beats with crop (0,0) → frame_err pulses once, no tlast, and the next frame's first output carries tuser[0].
- Deassert s_axis_resetn mid-ACTIVE with an output pending → all outputs 0 immediately; after release the next SOF frame is output normally.
